smi_mem_req_type_router: RTL

Front stage of the SMI-to-AXI memory bridge. It demultiplexes incoming SMI request frames by the frame type byte to the read adaptor or the write adaptor, which only ever see pre-filtered frames. It also merges the two adaptors' SMI response streams back onto one response port with frame-atomic round-robin arbitration.

---
 rtl/smi_frame_pkg.sv | 29 ++
 rtl/smi_mem_req_type_router_if.sv | 12 +
 rtl/smi_mem_req_type_router_flit_reg.sv | 41 ++++
 rtl/smi_mem_req_type_router.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/smi_frame_pkg.sv
// SMI frame definitions shared by the request router, its output buffers and the response arbiter.
package smi_frame_pkg;

  localparam logic [7:0] READ_REQ_ID   = 8'h01;
  localparam logic [7:0] WRITE_REQ_ID  = 8'h02;
  localparam logic [7:0] READ_RESP_ID  = 8'hFD;
  localparam logic [7:0] WRITE_RESP_ID = 8'hFE;

  // Eofc of zero marks a mid-frame flit; any non-zero value ends the frame.
  localparam logic [7:0] EOFC_MID = 8'h00;

  typedef enum logic [1:0] {RouteIdle, RouteForward, RouteDrop} routeState_t;
  typedef enum logic       {RespIdle, RespLocked}                respState_t;
  typedef enum logic [1:0] {TargetRead, TargetWrite, TargetNone} routeTarget_t;
  typedef enum logic       {GrantRead, GrantWrite}               respGrant_t;

  function automatic logic isLastFlit(input logic [7:0] eofc);
    return eofc != EOFC_MID;
  endfunction

  function automatic routeTarget_t decodeTarget(input logic [7:0] typeByte);
    case (typeByte)
      READ_REQ_ID:  return TargetRead;
      WRITE_REQ_ID: return TargetWrite;
      default:      return TargetNone;
    endcase
  endfunction

endpackage

// File: rtl/smi_mem_req_type_router_if.sv
// One SMI flit link: Ready/Eofc/Data travel downstream, Stop travels upstream.
interface smi_mem_req_type_router_if #(
  parameter int DataWidth = 128
);
  logic                 ready;
  logic [7:0]           eofc;
  logic [DataWidth-1:0] data;
  logic                 stop;

  modport master (output ready, eofc, data, input stop);
  modport slave  (input ready, eofc, data, output stop);
endinterface

// File: rtl/smi_mem_req_type_router_flit_reg.sv
// smi_flit_output_reg: registered one-flit buffer driving an SMI link with 1-cycle latency
// and full throughput (it reloads in the same cycle its current flit is accepted).
module smi_flit_output_reg #(
  parameter int DataWidth = 128
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 loadValid,
  input  logic [7:0]           loadEofc,
  input  logic [DataWidth-1:0] loadData,
  output logic                 canLoad,
  smi_mem_req_type_router_if.master outLink
);

  logic                 full;
  logic [7:0]           eofcReg;
  logic [DataWidth-1:0] dataReg;

  assign canLoad = !full || !outLink.stop;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  // NOTE: data registers are reset as well because Eofc/Data must read 0 while in reset.
  always_ff @(posedge clk or negedge srst) begin
    if (!srst) begin
      full    <= 1'b0;
      eofcReg <= '0;
      dataReg <= '0;
    end else if (loadValid && canLoad) begin
      full    <= 1'b1;
      eofcReg <= loadEofc;
      dataReg <= loadData;
    end else if (full && !outLink.stop) begin
      full    <= 1'b0;
    end
  end

  assign outLink.ready = full;
  assign outLink.eofc  = eofcReg;
  assign outLink.data  = dataReg;

endmodule

// File: rtl/smi_mem_req_type_router.sv
// SMI memory-bridge front stage: routes request frames by type byte to the read/write adaptors
// and merges their responses with frame-atomic round robin. Optional: SMI_REQ_DROP_COUNT_EN.
module smi_mem_req_type_router
  import smi_frame_pkg::*;
#(
  parameter int DataIndexSize = 4
) (
  input  logic clk,
  input  logic srst,
  smi_mem_req_type_router_if.slave  smiReq,
  smi_mem_req_type_router_if.master rdReq,
  smi_mem_req_type_router_if.master wrReq,
  smi_mem_req_type_router_if.slave  rdResp,
  smi_mem_req_type_router_if.slave  wrResp,
  smi_mem_req_type_router_if.master smiResp
`ifdef SMI_REQ_DROP_COUNT_EN
  ,
  output logic [15:0] dropCount
`endif
);

  localparam int DataWidth = (1 << DataIndexSize) * 8;

  // ---------------- Request routing ----------------
  routeState_t  routeState, routeNext;
  routeTarget_t routeReg, routeRegNext, curTarget;
  logic         rdCanLoad, wrCanLoad;
  logic         reqFire, reqLast;

  // In RouteIdle the first flit's type byte picks the target in the same cycle.
  // NOTE: every signal gets a default first so no path through the block infers a latch.
  always_comb begin
    curTarget   = routeReg;
    smiReq.stop = 1'b0;
    if (routeState == RouteIdle) curTarget = decodeTarget(smiReq.data[7:0]);
    case (curTarget)
      TargetRead:  smiReq.stop = !rdCanLoad;
      TargetWrite: smiReq.stop = !wrCanLoad;
      default:     smiReq.stop = 1'b0;
    endcase
  end

  assign reqFire = smiReq.ready && !smiReq.stop;
  assign reqLast = isLastFlit(smiReq.eofc);

  always_comb begin
    routeNext    = routeState;
    routeRegNext = routeReg;
    case (routeState)
      RouteIdle: begin
        if (reqFire) begin
          routeRegNext = curTarget;
          if (!reqLast) routeNext = (curTarget == TargetNone) ? RouteDrop : RouteForward;
        end
      end
      RouteForward, RouteDrop: begin
        if (reqFire && reqLast) routeNext = RouteIdle;
      end
      default: routeNext = RouteIdle;
    endcase
  end

  always_ff @(posedge clk or negedge srst) begin
    if (!srst) begin
      routeState <= RouteIdle;
      routeReg   <= TargetNone;
    end else begin
      routeState <= routeNext;
      routeReg   <= routeRegNext;
    end
  end

  smi_flit_output_reg #(.DataWidth(DataWidth)) u_rdReqReg (
    .clk       (clk),
    .srst      (srst),
    .loadValid (reqFire && (curTarget == TargetRead)),
    .loadEofc  (smiReq.eofc),
    .loadData  (smiReq.data),
    .canLoad   (rdCanLoad),
    .outLink   (rdReq)
  );

  smi_flit_output_reg #(.DataWidth(DataWidth)) u_wrReqReg (
    .clk       (clk),
    .srst      (srst),
    .loadValid (reqFire && (curTarget == TargetWrite)),
    .loadEofc  (smiReq.eofc),
    .loadData  (smiReq.data),
    .canLoad   (wrCanLoad),
    .outLink   (wrReq)
  );

`ifdef SMI_REQ_DROP_COUNT_EN
  // One count per unknown-type frame, taken on its first flit; saturates.
  always_ff @(posedge clk or negedge srst) begin
    if (!srst) begin
      dropCount <= '0;
    end else if ((routeState == RouteIdle) && reqFire && (curTarget == TargetNone)
                 && (dropCount != 16'hFFFF)) begin
      dropCount <= dropCount + 16'd1;
    end
  end
`endif

  // ---------------- Response arbitration ----------------
  respState_t           respState, respNext;
  respGrant_t           grantReg, grantRegNext, curGrant, lastGrant, lastGrantNext;
  logic                 respCanLoad, respValid, respFire;
  logic [7:0]           respEofc;
  logic [DataWidth-1:0] respData;

  // A new grant is only chosen between frames; a tie goes to the input not granted last.
  always_comb begin
    curGrant = grantReg;
    if (respState == RespIdle) begin
      if (rdResp.ready && (!wrResp.ready || (lastGrant == GrantWrite))) curGrant = GrantRead;
      else if (wrResp.ready)                                             curGrant = GrantWrite;
      else                                                               curGrant = GrantRead;
    end
    rdResp.stop = !((curGrant == GrantRead)  && respCanLoad);
    wrResp.stop = !((curGrant == GrantWrite) && respCanLoad);
    if (curGrant == GrantRead) begin
      respValid = rdResp.ready;
      respEofc  = rdResp.eofc;
      respData  = rdResp.data;
    end else begin
      respValid = wrResp.ready;
      respEofc  = wrResp.eofc;
      respData  = wrResp.data;
    end
  end

  assign respFire = respValid && respCanLoad;

  always_comb begin
    respNext      = respState;
    grantRegNext  = grantReg;
    lastGrantNext = lastGrant;
    case (respState)
      RespIdle: begin
        if (respFire) begin
          grantRegNext  = curGrant;
          lastGrantNext = curGrant;
          if (!isLastFlit(respEofc)) respNext = RespLocked;
        end
      end
      RespLocked: begin
        if (respFire && isLastFlit(respEofc)) respNext = RespIdle;
      end
      default: respNext = RespIdle;
    endcase
  end

  always_ff @(posedge clk or negedge srst) begin
    if (!srst) begin
      respState <= RespIdle;
      grantReg  <= GrantWrite;
      lastGrant <= GrantWrite;
    end else begin
      respState <= respNext;
      grantReg  <= grantRegNext;
      lastGrant <= lastGrantNext;
    end
  end

  smi_flit_output_reg #(.DataWidth(DataWidth)) u_respReg (
    .clk       (clk),
    .srst      (srst),
    .loadValid (respFire),
    .loadEofc  (respEofc),
    .loadData  (respData),
    .canLoad   (respCanLoad),
    .outLink   (smiResp)
  );

endmodule
